wb_stage_mlane: RTL and testbench

Parametrised multi-lane MEM/WB pipeline stage for the dual-issue core; sits between the MEM stage and the register file / HI-LO unit. Registers up to LANES retiring instructions per cycle and adds a valid/ready handshake backed by a two-entry skid buffer, so the register file can back-pressure. Also adds flush, same-bundle write-after-write squashing, $zero-write suppression and a dedicated 64-bit HI/LO writeback path.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_skid_buf.sv | 80 ++++++++
 rtl/wb_stage_mlane.sv | 81 ++++++++
 tb/tb_wb_stage_mlane.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the multi-lane MEM/WB stage: lane/bundle records and buffer state.
package wb_pkg;
  localparam int WB_LANES  = 2;
  localparam int WB_DATA_W = 32;
  localparam int WB_REG_AW = 5;

  localparam logic [WB_REG_AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [WB_REG_AW-1:0] wd;
    logic                 reg_we;
    logic [WB_DATA_W-1:0] wdata;
  } wb_lane_t;

  typedef struct packed {
    wb_lane_t [WB_LANES-1:0] lanes;
    logic                    hilo_we;
    logic [2*WB_DATA_W-1:0]  hilo;
  } wb_bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
endpackage

// File: rtl/wb_skid_buf.sv
// Two-entry skid buffer with flush; main entry drives the outputs, ready is registered.
module wb_skid_buf
  import wb_pkg::*;
#(
  parameter type T = wb_bundle_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);
  state_t state, state_nx;
  T       main_q, skid_q;
  logic   ready_q, accept, deliver;
  logic   load_main, load_skid, from_skid;

  assign accept    = in_valid && ready_q;
  assign deliver   = (state != EMPTY) && out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (state != EMPTY);
  assign out_data  = out_valid ? main_q : '0;

  always_comb begin
    state_nx  = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_nx  = ONE;
        load_main = 1'b1;
      end
      ONE: begin
        if (accept && deliver) load_main = 1'b1;
        else if (accept) begin
          state_nx  = TWO;
          load_skid = 1'b1;
        end else if (deliver) state_nx = EMPTY;
      end
      TWO: if (deliver) begin
        state_nx  = ONE;
        from_skid = 1'b1;
      end
      default: state_nx = EMPTY;
    endcase
    if (flush) begin
      state_nx  = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      from_skid = 1'b0;
    end
  end

  // ready tracks "skid not occupied" one cycle ahead so it comes straight from a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nx;
      ready_q <= (state_nx != TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)      main_q <= in_data;
      else if (from_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= in_data;
    end
  end
endmodule

// File: rtl/wb_stage_mlane.sv
// Multi-lane MEM/WB stage: squashes same-bundle WAW and $zero writes, picks HI/LO, then buffers.
module wb_stage_mlane
  import wb_pkg::*;
#(
  parameter int LANES  = WB_LANES,
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_AW = WB_REG_AW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      mem_valid_i,
  output logic                      mem_ready_o,
  input  logic [LANES*REG_AW-1:0]   mem_wd_i,
  input  logic [LANES-1:0]          mem_reg_i,
  input  logic [LANES*2*DATA_W-1:0] mem_wdata_i,
  input  logic [LANES-1:0]          mem_hilo_i,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [LANES*REG_AW-1:0]   wb_wd_o,
  output logic [LANES-1:0]          wb_reg_o,
  output logic [LANES*DATA_W-1:0]   wb_wdata_o,
  output logic                      wb_hilo_we_o,
  output logic [2*DATA_W-1:0]       wb_hilo_o
);
  wb_bundle_t       cap, out;
  logic [LANES-1:0] kill;

  // a lane loses its GPR write to $zero or to any younger lane targeting the same register
  always_comb begin
    kill = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mem_wd_i[i*REG_AW +: REG_AW] == ZERO_REG) kill[i] = 1'b1;
      for (int j = i + 1; j < LANES; j++)
        if (mem_reg_i[j] && mem_wd_i[j*REG_AW +: REG_AW] == mem_wd_i[i*REG_AW +: REG_AW])
          kill[i] = 1'b1;
    end
  end

  // later lanes overwrite HI/LO so the youngest writer wins
  always_comb begin
    cap = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mem_reg_i[i] && !kill[i]) begin
        cap.lanes[i].wd     = mem_wd_i[i*REG_AW +: REG_AW];
        cap.lanes[i].reg_we = 1'b1;
        cap.lanes[i].wdata  = mem_wdata_i[i*2*DATA_W +: DATA_W];
      end
      if (mem_hilo_i[i]) begin
        cap.hilo_we = 1'b1;
        cap.hilo    = mem_wdata_i[i*2*DATA_W +: 2*DATA_W];
      end
    end
  end

  wb_skid_buf #(.T(wb_bundle_t)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_i),
    .in_valid  (mem_valid_i),
    .in_ready  (mem_ready_o),
    .in_data   (cap),
    .out_valid (wb_valid_o),
    .out_ready (wb_ready_i),
    .out_data  (out)
  );

  always_comb begin
    wb_wd_o    = '0;
    wb_reg_o   = '0;
    wb_wdata_o = '0;
    for (int i = 0; i < LANES; i++) begin
      wb_wd_o[i*REG_AW +: REG_AW]    = out.lanes[i].wd;
      wb_reg_o[i]                    = out.lanes[i].reg_we;
      wb_wdata_o[i*DATA_W +: DATA_W] = out.lanes[i].wdata;
    end
  end

  assign wb_hilo_we_o = out.hilo_we;
  assign wb_hilo_o    = out.hilo;
endmodule

// File: tb/tb_wb_stage_mlane.sv
// Bench for wb_stage_mlane: directed vector table, handshake corner sequences, random vs queue model.
module tb_wb_stage_mlane;
  localparam int L = 2, DW = 32, AW = 5;

  typedef struct packed {
    logic [L*AW-1:0] wd;
    logic [L-1:0]    rg;
    logic [L*DW-1:0] wdata;
    logic            hilo_we;
    logic [2*DW-1:0] hilo;
  } exp_t;

  typedef struct {
    logic [L*AW-1:0]   wd;
    logic [L-1:0]      rg;
    logic [L*2*DW-1:0] wdata;
    logic [L-1:0]      hilo;
    exp_t              exp;
  } vec_t;

  logic              clk = 0, rst = 1, flush = 0, mem_valid = 0, wb_ready = 0;
  logic [L*AW-1:0]   mem_wd = '0;
  logic [L-1:0]      mem_reg = '0, mem_hilo = '0;
  logic [L*2*DW-1:0] mem_wdata = '0;
  logic              mem_ready_o, wb_valid_o, wb_hilo_we_o;
  logic [L*AW-1:0]   wb_wd_o;
  logic [L-1:0]      wb_reg_o;
  logic [L*DW-1:0]   wb_wdata_o;
  logic [2*DW-1:0]   wb_hilo_o;

  int checks = 0, errors = 0;
  vec_t vecs[7];
  exp_t q[$];
  logic [DW-1:0] got[$];

  always #5 clk = ~clk;

  wb_stage_mlane #(.LANES(L), .DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .mem_valid_i(mem_valid), .mem_ready_o(mem_ready_o),
    .mem_wd_i(mem_wd), .mem_reg_i(mem_reg), .mem_wdata_i(mem_wdata), .mem_hilo_i(mem_hilo),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready),
    .wb_wd_o(wb_wd_o), .wb_reg_o(wb_reg_o), .wb_wdata_o(wb_wdata_o),
    .wb_hilo_we_o(wb_hilo_we_o), .wb_hilo_o(wb_hilo_o)
  );

  // Reference: a lane writes iff enabled, not $zero, and no younger enabled lane shares its wd
  function automatic exp_t model(input logic [L*AW-1:0] wd, input logic [L-1:0] rg,
                                 input logic [L*2*DW-1:0] wdata, input logic [L-1:0] hilo);
    exp_t e;
    bit keep;
    e = '0;
    for (int i = 0; i < L; i++) begin
      keep = rg[i] && (wd[i*AW +: AW] != '0);
      for (int j = i + 1; j < L; j++)
        if (rg[j] && wd[j*AW +: AW] == wd[i*AW +: AW]) keep = 0;
      if (keep) begin
        e.wd[i*AW +: AW]    = wd[i*AW +: AW];
        e.rg[i]             = 1'b1;
        e.wdata[i*DW +: DW] = wdata[i*2*DW +: DW];
      end
    end
    for (int i = L - 1; i >= 0; i--)
      if (hilo[i]) begin
        e.hilo_we = 1'b1;
        e.hilo    = wdata[i*2*DW +: 2*DW];
        break;
      end
    return e;
  endfunction

  function automatic exp_t actual();
    return {wb_wd_o, wb_reg_o, wb_wdata_o, wb_hilo_we_o, wb_hilo_o};
  endfunction

  function automatic vec_t mk(input logic [L*AW-1:0] wd, input logic [L-1:0] rg,
                              input logic [L*2*DW-1:0] wdata, input logic [L-1:0] hilo,
                              input exp_t e);
    vec_t v;
    v.wd = wd; v.rg = rg; v.wdata = wdata; v.hilo = hilo; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    mem_valid = 0; mem_reg = '0; mem_wd = '0; mem_wdata = '0; mem_hilo = '0; flush = 0;
  endtask

  task automatic put(input logic [AW-1:0] wd0, input logic [DW-1:0] d0);
    idle();
    mem_valid = 1; mem_reg = 2'b01;
    mem_wd[AW-1:0] = wd0;
    mem_wdata[DW-1:0] = d0;
  endtask

  initial begin
    vecs[0] = mk({5'd4, 5'd3}, 2'b11, {64'h22, 64'h11}, 2'b00,
                 {{5'd4, 5'd3}, 2'b11, {32'h22, 32'h11}, 1'b0, 64'h0});
    vecs[1] = mk({5'd7, 5'd7}, 2'b11, {64'hB, 64'hA}, 2'b00,
                 {{5'd7, 5'd0}, 2'b10, {32'hB, 32'h0}, 1'b0, 64'h0});
    vecs[2] = mk({5'd5, 5'd0}, 2'b11, {64'h55, 64'h44}, 2'b00,
                 {{5'd5, 5'd0}, 2'b10, {32'h55, 32'h0}, 1'b0, 64'h0});
    vecs[3] = mk({5'd0, 5'd0}, 2'b00, {64'h3_00000004, 64'h1_00000002}, 2'b11,
                 {10'h0, 2'b00, 64'h0, 1'b1, 64'h3_00000004});
    vecs[4] = mk({5'd9, 5'd2}, 2'b10, {64'hAAAA5555_DEADBEEF, 64'h7_00000008}, 2'b01,
                 {{5'd9, 5'd0}, 2'b10, {32'hDEADBEEF, 32'h0}, 1'b1, 64'h7_00000008});
    vecs[5] = mk({5'd6, 5'd6}, 2'b01, {64'h66, 64'h77}, 2'b00,
                 {{5'd0, 5'd6}, 2'b01, {32'h0, 32'h77}, 1'b0, 64'h0});
    vecs[6] = mk({5'd3, 5'd3}, 2'b11, {64'h9_0000000A, 64'h5}, 2'b10,
                 {{5'd3, 5'd0}, 2'b10, {32'hA, 32'h0}, 1'b1, 64'h9_0000000A});

    // reset state
    idle(); rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_valid", wb_valid_o, 1'b0);
    chk("reset_ready", mem_ready_o, 1'b1);
    chk("reset_data", actual(), '0);

    // directed vectors, one bundle at a time, single-cycle latency
    wb_ready = 1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("vec_gap_valid", wb_valid_o, 1'b0);
      idle();
      mem_valid = 1; mem_wd = vecs[k].wd; mem_reg = vecs[k].rg;
      mem_wdata = vecs[k].wdata; mem_hilo = vecs[k].hilo;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", k), wb_valid_o, 1'b1);
      chk($sformatf("vec%0d_data", k), actual(), vecs[k].exp);
      idle();
    end

    // stream of 5 with a 3-cycle stall
    begin
      int  sent;
      bit  saw_low;
      sent = 0; saw_low = 0; got.delete();
      for (int c = 0; c < 40 && got.size() < 5; c++) begin
        @(negedge clk);
        if (!mem_ready_o) saw_low = 1;
        wb_ready = !(c >= 2 && c <= 4);
        idle();
        if (sent < 5 && mem_ready_o) begin
          put(AW'(sent + 1), DW'(32'h100 + sent));
          sent++;
        end
        if (wb_valid_o && wb_ready) got.push_back(wb_wdata_o[DW-1:0]);
      end
      chk("stream_count", got.size(), 5);
      chk("stream_ready_fell", saw_low, 1'b1);
      for (int k = 0; k < 5; k++)
        if (k < got.size()) chk($sformatf("stream_order%0d", k), got[k], 32'h100 + k);
      @(negedge clk);
      idle(); wb_ready = 1;
      @(negedge clk);
      chk("stream_drained", wb_valid_o, 1'b0);
    end

    // fill both entries, then flush alongside a new bundle
    wb_ready = 0; put(5'd10, 32'hA0);
    @(negedge clk); put(5'd11, 32'hA1);
    @(negedge clk);
    chk("two_ready_low", mem_ready_o, 1'b0);
    chk("two_valid", wb_valid_o, 1'b1);
    put(5'd12, 32'hA2); flush = 1;
    @(negedge clk);
    chk("flush_valid", wb_valid_o, 1'b0);
    chk("flush_ready", mem_ready_o, 1'b1);
    chk("flush_data", actual(), '0);
    idle(); wb_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_nothing_out", wb_valid_o, 1'b0);
    end

    // reset with a full buffer, then accept right after release
    wb_ready = 0; put(5'd13, 32'hB0);
    @(negedge clk); put(5'd14, 32'hB1);
    @(negedge clk);
    idle(); rst = 1;
    @(negedge clk);
    chk("rst_full_valid", wb_valid_o, 1'b0);
    chk("rst_full_ready", mem_ready_o, 1'b1);
    chk("rst_full_data", actual(), '0);
    rst = 0; wb_ready = 1; put(5'd12, 32'hD0);
    @(negedge clk);
    chk("post_rst_valid", wb_valid_o, 1'b1);
    chk("post_rst_data", actual(), model(mem_wd, mem_reg, mem_wdata, mem_hilo));
    idle();
    @(negedge clk);

    // random traffic against a bundle queue
    rst = 1;
    @(negedge clk);
    rst = 0; q.delete();
    for (int c = 0; c < 400; c++) begin
      int n;
      @(negedge clk);
      chk("rand_valid", wb_valid_o, q.size() > 0);
      chk("rand_ready", mem_ready_o, q.size() < 2);
      chk("rand_data", actual(), q.size() > 0 ? q[0] : '0);
      idle();
      flush     = ($urandom_range(0, 29) == 0);
      mem_valid = ($urandom_range(0, 3) != 0);
      wb_ready  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < L; i++) mem_wd[i*AW +: AW] = AW'($urandom_range(0, 7));
      mem_reg   = L'($urandom);
      mem_hilo  = ($urandom_range(0, 3) == 0) ? L'($urandom) : '0;
      mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      n = q.size();
      if (flush) q.delete();
      else begin
        if (n > 0 && wb_ready) void'(q.pop_front());
        if (mem_valid && n < 2) q.push_back(model(mem_wd, mem_reg, mem_wdata, mem_hilo));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
